dac7512_tx: RTL and testbench

Serial write driver for a 12-bit SPI DAC (DAC7512-class, 16-bit frame, data sampled by the DAC on falling SCK), the output-side counterpart of the ADC serial readers in this codebase. Accepts a 12-bit code plus a 2-bit power-down mode on a one-cycle strobe and shifts one frame MSB-first while holding cs low. A one-deep holding register absorbs a request that arrives mid-frame, so software or a sample-rate timer can issue codes back-to-back.

---
 rtl/dac7512_pkg.sv | 20 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/dac7512_tx.sv | 162 ++++++++++++++++
 tb/tb_dac7512_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dac7512_pkg.sv
// Shared types and helpers for the DAC7512 serial write driver.
// Frame layout: two zero bits, power-down mode, 12-bit code.
package dac7512_pkg;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [1:0]  pd,
    input logic [11:0] data
  );
    return {2'b00, pd, data};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for SCK.
// The count is held at zero while disabled, so each frame starts aligned.
module spi_clk_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/dac7512_tx.sv
// DAC7512 serial write driver: 16-bit MSB-first frame, DAC samples on
// falling SCK, one-deep pending register for back-to-back requests.
module dac7512_tx #(
  parameter int CLK_DIV = 1,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] data,
  input  logic [1:0]  pd,
  output logic        cs,
  output logic        sck,
  output logic        sdi,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  import dac7512_pkg::*;

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [4:0] ALL_BITS = 5'(FRAME_BITS);

  state_t r_state;
  state_t w_state_nxt;

  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic [FRAME_BITS-1:0] r_pend, w_pend_nxt;
  logic [FRAME_BITS-1:0] w_new, w_src;
  logic [4:0] r_bits, w_bits_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic r_pend_vld, w_pend_vld_nxt;
  logic r_cs, w_cs_nxt;
  logic r_sck, w_sck_nxt;
  logic r_sdi, w_sdi_nxt;
  logic r_busy, w_busy_nxt;
  logic r_done, w_done_nxt;
  logic r_ovf, w_ovf_nxt;
  logic w_tick;
  logic w_start;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == SHIFT),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_bits     <= '0;
      r_gap      <= '0;
      r_cs       <= 1'b1;
      r_sck      <= 1'b1;
      r_sdi      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_bits     <= w_bits_nxt;
      r_gap      <= w_gap_nxt;
      r_cs       <= w_cs_nxt;
      r_sck      <= w_sck_nxt;
      r_sdi      <= w_sdi_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    w_bits_nxt     = r_bits;
    w_gap_nxt      = r_gap;
    w_cs_nxt       = r_cs;
    w_sck_nxt      = r_sck;
    w_sdi_nxt      = r_sdi;
    w_done_nxt     = 1'b0;
    w_ovf_nxt      = 1'b0;
    w_start        = 1'b0;
    w_new          = build_frame(pd, data);
    w_src          = r_pend_vld ? r_pend : w_new;

    unique case (r_state)
      IDLE: begin
        if (r_pend_vld || en) w_start = 1'b1;
      end
      SHIFT: begin
        if (w_tick) begin
          if (r_sck) begin
            w_sck_nxt  = 1'b0;
            w_bits_nxt = r_bits + 5'd1;
          end else if (r_bits == ALL_BITS) begin
            w_sck_nxt   = 1'b1;
            w_cs_nxt    = 1'b1;
            w_sdi_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
            w_gap_nxt   = '0;
            w_state_nxt = GAP;
          end else begin
            w_sck_nxt   = 1'b1;
            w_shift_nxt = r_shift << 1;
            w_sdi_nxt   = r_shift[FRAME_BITS-2];
          end
        end
      end
      GAP: begin
        if (r_gap == GAP_LAST) begin
          if (r_pend_vld) w_start = 1'b1;
          else w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_start) begin
      w_shift_nxt = w_src;
      w_sdi_nxt   = w_src[FRAME_BITS-1];
      w_cs_nxt    = 1'b0;
      w_sck_nxt   = 1'b1;
      w_bits_nxt  = '0;
      w_state_nxt = SHIFT;
    end

    // A request consumed directly by an idle start never touches pending.
    if (w_start && r_pend_vld) begin
      w_pend_vld_nxt = en;
      if (en) w_pend_nxt = w_new;
    end else if (!w_start && en) begin
      w_ovf_nxt      = r_pend_vld;
      w_pend_nxt     = w_new;
      w_pend_vld_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign cs   = r_cs;
  assign sck  = r_sck;
  assign sdi  = r_sdi;
  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_dac7512_tx.sv
// Bench for dac7512_tx: two configurations checked cycle by cycle
// against a request-level timeline model.
module tb_dac7512_tx;

  logic clk = 1'b0;
  logic rst;
  logic en1, en4;
  logic [11:0] data;
  logic [1:0] pd;
  logic cs1, sck1, sdi1, busy1, done1, ovf1;
  logic cs4, sck4, sdi4, busy4, done4, ovf4;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dac7512_tx #(.CLK_DIV(1), .GAP_CYC(2)) u_d1 (
    .clk(clk), .rst(rst), .en(en1), .data(data), .pd(pd),
    .cs(cs1), .sck(sck1), .sdi(sdi1), .busy(busy1),
    .done(done1), .ovf(ovf1)
  );

  dac7512_tx #(.CLK_DIV(4), .GAP_CYC(3)) u_d4 (
    .clk(clk), .rst(rst), .en(en4), .data(data), .pd(pd),
    .cs(cs4), .sck(sck4), .sdi(sdi4), .busy(busy4),
    .done(done4), .ovf(ovf4)
  );

  bit sel = 1'b0;
  int D = 1;
  int G = 2;
  int s_q[$];
  logic [15:0] f_q[$];
  int ovf_q[$];
  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [5:0] obs,
                     input logic [5:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp);
  endtask

  // Expected {cs,sck,sdi,done,busy,ovf} from the scheduled frames.
  task automatic check_cycle(input string tag);
    logic ecs, esck, esdi, edone, ebusy, eovf, infr;
    logic [5:0] ob;
    ecs = 1; esck = 1; esdi = 0; edone = 0;
    ebusy = 0; eovf = 0; infr = 0;
    foreach (s_q[i]) begin
      int o;
      o = cyc - s_q[i];
      if (o >= 0 && o < 32 * D) begin
        infr = 1;
        ecs = 0;
        esck = ((o / D) % 2 == 0);
        esdi = f_q[i][15 - o / (2 * D)];
      end
      if (o == 32 * D) edone = 1;
      if (o >= 0 && o < 32 * D + G) ebusy = 1;
    end
    foreach (ovf_q[i]) if (ovf_q[i] == cyc) eovf = 1;
    ob = sel ? {cs4, sck4, sdi4, done4, busy4, ovf4}
             : {cs1, sck1, sdi1, done1, busy1, ovf1};
    if (!infr && ebusy) ob[3] = 1'b0;
    chk(tag, ob, {ecs, esck, esdi, edone, ebusy, eovf});
  endtask

  task automatic clear_model();
    s_q.delete();
    f_q.delete();
    ovf_q.delete();
  endtask

  task automatic step(input bit go, input logic [11:0] d,
                      input logic [1:0] p);
    int c, e, st;
    logic [15:0] fr;
    @(negedge clk);
    check_cycle(sel ? "d4" : "d1");
    en1 = 0;
    en4 = 0;
    if (go) begin
      c = cyc;
      fr = {2'b00, p, d};
      if (s_q.size() > 0 && c < s_q[s_q.size()-1] - 1) begin
        f_q[f_q.size()-1] = fr;
        ovf_q.push_back(c + 1);
      end else begin
        if (s_q.size() == 0) begin
          st = c + 1;
        end else begin
          e = s_q[s_q.size()-1] + 32 * D + G - 1;
          if (c < e) st = e + 1;
          else if (c == e) st = e + 2;
          else st = c + 1;
        end
        s_q.push_back(st);
        f_q.push_back(fr);
      end
      data = d;
      pd = p;
      if (sel) en4 = 1;
      else en1 = 1;
    end else begin
      data = 12'($urandom);
      pd = 2'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 12'h000, 2'b00);
  endtask

  initial begin
    rst = 1;
    en1 = 0;
    en4 = 0;
    data = 0;
    pd = 0;
    repeat (2) @(negedge clk);
    check_cycle("reset1");
    chk("reset4", {cs4, sck4, sdi4, done4, busy4, ovf4}, 6'b110000);
    rst = 0;

    step(1, 12'hA5C, 2'b00);
    idle(40);
    step(1, 12'h000, 2'b11);
    idle(40);

    step(1, 12'h111, 2'b00);
    idle(4);
    step(1, 12'h222, 2'b00);
    idle(80);

    step(1, 12'h111, 2'b00);
    idle(4);
    step(1, 12'h222, 2'b00);
    idle(3);
    step(1, 12'h333, 2'b00);
    idle(80);

    step(1, 12'hABC, 2'b01);
    idle(12);
    #2 rst = 1;
    #1 clear_model();
    check_cycle("rst_async");
    idle(2);
    rst = 0;
    step(1, 12'h5A3, 2'b10);
    idle(40);

    repeat (25) begin
      step(1, 12'($urandom), 2'($urandom));
      idle($urandom_range(0, 45));
    end
    idle(80);

    clear_model();
    sel = 1;
    D = 4;
    G = 3;
    step(1, 12'hA5C, 2'b00);
    idle(5);
    step(1, 12'h3C3, 2'b10);
    idle(300);
    repeat (12) begin
      step(1, 12'($urandom), 2'($urandom));
      idle($urandom_range(0, 180));
    end
    idle(300);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
